fetch_sequencer: RTL and testbench
==================================

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 Parameter TIMEOUT, default 16: maximum FETCH cycles allowed without i_imem_ack; legal range 2..255.
REQ-002 i_clk  input  1  single clock; all state updates on its rising edge.
REQ-003 i_reset  input  1  synchronous, active-high reset.
REQ-004 i_start  input  1  one-cycle start pulse; honoured only in IDLE.
REQ-005 i_pc  input  32  current PC from the program counter register.
REQ-006 i_imem_ack  input  1  instruction memory ack; i_imem_rdata is valid in the same cycle.
REQ-007 i_imem_rdata  input  32  fetched instruction word.
REQ-008 i_exec_done  input  1  execute/writeback finished for the held instruction.
REQ-009 i_redirect  input  1  taken branch/jump; sampled only with i_exec_done.
REQ-010 i_halt  input  1  ecall/ebreak seen; sampled only with i_exec_done.
REQ-011 o_imem_req  output  1  fetch request, held high through FETCH.
REQ-012 o_imem_addr  output  32  equals i_pc while o_imem_req is high, else 0.
REQ-013 o_ir  output  32  latched instruction register.
REQ-014 o_ir_valid  output  1  high in EXEC only.
REQ-015 o_pc_en  output  1  one-cycle PC update strobe.
REQ-016 o_pc_sel  output  1  PC source: 0 = sequential (pc_4 path), 1 = writeback target.
REQ-017 o_instret  output  32  retired-instruction counter.
REQ-018 o_state  output  3  encoded FSM state.
REQ-019 o_fault  output  1  sticky fetch-timeout flag.

Function
REQ-020 FSM states and o_state encoding: IDLE=0, FETCH=1, EXEC=2, UPDATE=3, FAULT=4; no other values reachable.
REQ-021 IDLE: all strobes low; i_start=1 moves to FETCH next cycle.
REQ-022 FETCH: o_imem_req=1; i_imem_ack=1 loads o_ir from i_imem_rdata and moves to EXEC next cycle.
REQ-023 FETCH wait counter clears on FETCH entry and increments each FETCH cycle without ack.
REQ-024 Counter reaching TIMEOUT-1 with no ack moves to FAULT and sets o_fault.
REQ-025 Ack in the same cycle the counter reaches TIMEOUT-1: ack wins and the FSM goes to EXEC with no fault.
REQ-026 EXEC: o_ir stable, o_ir_valid=1; i_exec_done=1 latches i_redirect and i_halt and moves to UPDATE.
REQ-027 UPDATE lasts exactly one cycle: o_pc_en=1, o_pc_sel=latched redirect, o_instret increments by 1.
REQ-028 UPDATE exit: latched halt=1 goes to IDLE; otherwise goes to FETCH.
REQ-029 Redirect and halt together: PC still takes the redirect target, then the FSM goes to IDLE.
REQ-030 o_pc_sel=0 in every state except UPDATE with latched redirect=1.
REQ-031 o_instret wraps from 0xFFFF_FFFF to 0 without a flag.
REQ-032 FAULT is terminal until reset; i_start ignored; all strobes low; o_fault=1.
REQ-033 i_start outside IDLE, i_imem_ack outside FETCH and i_exec_done outside EXEC have no effect.
REQ-034 Minimum loop latency per instruction is 3 cycles (FETCH with immediate ack, EXEC with immediate done, UPDATE).

Reset
REQ-035 i_reset=1 at a clock edge forces IDLE from any state, including mid-FETCH and FAULT.
REQ-036 Reset values: o_ir=0, o_instret=0, o_fault=0, latched redirect/halt=0, wait counter=0.
REQ-037 During and after reset: o_imem_req=0, o_ir_valid=0, o_pc_en=0, o_pc_sel=0.
REQ-038 Reset takes priority over every other input in the same cycle.

Verification
REQ-039 Reset, i_start, i_pc=0x0, immediate ack rdata=0x00500093, immediate exec_done, no redirect -> o_ir=0x00500093, UPDATE pulse with o_pc_sel=0, o_instret=1, back in FETCH.
REQ-040 exec_done with i_redirect=1 -> single o_pc_en cycle with o_pc_sel=1; next FETCH presents the new i_pc on o_imem_addr.
REQ-041 Ack withheld, TIMEOUT=16 -> FAULT (o_state=4) after 16 FETCH cycles, o_fault=1; i_start ignored; i_reset returns IDLE with o_fault=0.
REQ-042 Ack on the 16th FETCH cycle -> EXEC, o_fault stays 0.
REQ-043 exec_done with i_halt=1 and i_redirect=1 -> o_pc_en=1, o_pc_sel=1, then IDLE with o_instret incremented.
REQ-044 o_instret forced to 0xFFFF_FFFF, one retire -> o_instret=0; i_reset asserted mid-EXEC -> IDLE, o_ir=0 next cycle.

Source files
------------

// File: rtl/fetch_sequencer.sv
// fetch_sequencer
// Multi-cycle instruction fetch/execute sequencer for a simple RISC-V style
// core. Each instruction goes through FETCH (request held until the memory
// acks), EXEC (instruction register presented until execute reports done)
// and a single UPDATE cycle that strobes the PC and retires the instruction.
// A fetch that waits TIMEOUT cycles without an ack parks the FSM in FAULT
// until reset.
//
// Ports
//   i_clk, i_reset   clock, synchronous active-high reset
//   i_start          start pulse, honoured in IDLE only
//   i_pc             current PC, forwarded to o_imem_addr during FETCH
//   i_imem_ack       instruction memory ack, i_imem_rdata valid with it
//   i_imem_rdata     fetched instruction word
//   i_exec_done      execute/writeback finished (sampled in EXEC)
//   i_redirect       taken branch/jump, sampled with i_exec_done
//   i_halt           ecall/ebreak, sampled with i_exec_done
//   o_imem_req       fetch request (FETCH)
//   o_imem_addr      i_pc while o_imem_req is high, else 0
//   o_ir             instruction register
//   o_ir_valid       high in EXEC
//   o_pc_en          one-cycle PC update strobe (UPDATE)
//   o_pc_sel         0 = sequential PC, 1 = redirect target
//   o_instret        retired-instruction counter (wraps silently)
//   o_state          FSM state: IDLE=0 FETCH=1 EXEC=2 UPDATE=3 FAULT=4
//   o_fault          sticky fetch-timeout flag
//
// Handshake: the memory request is level-based; o_imem_req stays high for
// every FETCH cycle and the first cycle with i_imem_ack high completes the
// fetch. There is no backpressure on the ack side.
module fetch_sequencer #(
  parameter int TIMEOUT = 16
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_start,
  input  logic [31:0] i_pc,
  input  logic        i_imem_ack,
  input  logic [31:0] i_imem_rdata,
  input  logic        i_exec_done,
  input  logic        i_redirect,
  input  logic        i_halt,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  output logic [31:0] o_ir,
  output logic        o_ir_valid,
  output logic        o_pc_en,
  output logic        o_pc_sel,
  output logic [31:0] o_instret,
  output logic [2:0]  o_state,
  output logic        o_fault
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_EXEC   = 3'd2,
    S_UPDATE = 3'd3,
    S_FAULT  = 3'd4
  } state_t;

  localparam logic [7:0] LP_WAIT_LAST = 8'(TIMEOUT - 1);

  state_t      r_state;
  state_t      w_next;
  logic [7:0]  r_wait;
  logic [31:0] r_ir;
  logic [31:0] r_instret;
  logic        r_redirect;
  logic        r_halt;
  logic        r_fault;
  logic        w_wait_last;

  assign w_wait_last = (r_wait == LP_WAIT_LAST);

  // State register
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next state and decoded outputs
  always_comb begin
    w_next      = r_state;
    o_imem_req  = 1'b0;
    o_imem_addr = 32'h0;
    o_ir_valid  = 1'b0;
    o_pc_en     = 1'b0;
    o_pc_sel    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start) w_next = S_FETCH;
      end
      S_FETCH: begin
        o_imem_req  = 1'b1;
        o_imem_addr = i_pc;
        // Ack wins over the timeout when both land in the same cycle.
        if (i_imem_ack)       w_next = S_EXEC;
        else if (w_wait_last) w_next = S_FAULT;
      end
      S_EXEC: begin
        o_ir_valid = 1'b1;
        if (i_exec_done) w_next = S_UPDATE;
      end
      S_UPDATE: begin
        o_pc_en  = 1'b1;
        o_pc_sel = r_redirect;
        w_next   = r_halt ? S_IDLE : S_FETCH;
      end
      S_FAULT: begin
        w_next = S_FAULT;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Datapath registers
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wait     <= 8'd0;
      r_ir       <= 32'h0;
      r_instret  <= 32'h0;
      r_redirect <= 1'b0;
      r_halt     <= 1'b0;
      r_fault    <= 1'b0;
    end else begin
      // Wait counter is held at zero outside FETCH so every FETCH entry
      // starts counting from zero.
      if (r_state == S_FETCH) begin
        if (i_imem_ack) begin
          r_ir   <= i_imem_rdata;
          r_wait <= 8'd0;
        end else if (w_wait_last) begin
          r_fault <= 1'b1;
          r_wait  <= 8'd0;
        end else begin
          r_wait <= r_wait + 8'd1;
        end
      end else begin
        r_wait <= 8'd0;
      end

      if (r_state == S_EXEC && i_exec_done) begin
        r_redirect <= i_redirect;
        r_halt     <= i_halt;
      end

      if (r_state == S_UPDATE) begin
        r_instret <= r_instret + 32'd1;
      end
    end
  end

  assign o_ir      = r_ir;
  assign o_instret = r_instret;
  assign o_state   = r_state;
  assign o_fault   = r_fault;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer. The reference model works per instruction: a
// transaction (pc, word, ack delay, done delay, redirect, halt) determines
// how many FETCH and EXEC cycles must be seen, what the outputs show in each,
// and how the retire count and final state move afterwards.
module tb_fetch_sequencer;

  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] pc;
  logic        ack;
  logic [31:0] rdata;
  logic        done;
  logic        redirect;
  logic        halt;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] ir;
  logic        ir_valid;
  logic        pc_en;
  logic        pc_sel;
  logic [31:0] instret;
  logic [2:0]  state;
  logic        fault;

  int total = 0;
  int bad   = 0;

  // Model state
  logic [31:0] exp_ir;
  logic [31:0] exp_instret;
  logic [2:0]  exp_state;

  // Clock / reset
  always #5 clk = ~clk;

  fetch_sequencer #(.TIMEOUT(TIMEOUT)) dut (
    .i_clk        (clk),
    .i_reset      (rst),
    .i_start      (start),
    .i_pc         (pc),
    .i_imem_ack   (ack),
    .i_imem_rdata (rdata),
    .i_exec_done  (done),
    .i_redirect   (redirect),
    .i_halt       (halt),
    .o_imem_req   (imem_req),
    .o_imem_addr  (imem_addr),
    .o_ir         (ir),
    .o_ir_valid   (ir_valid),
    .o_pc_en      (pc_en),
    .o_pc_sel     (pc_sel),
    .o_instret    (instret),
    .o_state      (state),
    .o_fault      (fault)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet_inputs();
    start = 0; ack = 0; done = 0; redirect = 0; halt = 0;
    rdata = $urandom; pc = $urandom;
  endtask

  task automatic do_reset();
    rst = 1;
    start = 1; ack = 1; done = 1; redirect = 1; halt = 1;
    cycle();
    rst = 0;
    quiet_inputs();
    exp_ir = 0; exp_instret = 0; exp_state = 0;
    #1;
    chk("rst_state", 32'(state), 0);
    chk("rst_ir", ir, 0);
    chk("rst_instret", instret, 0);
    chk("rst_fault", 32'(fault), 0);
    chk("rst_strobes", {28'h0, imem_req, ir_valid, pc_en, pc_sel}, 0);
    chk("rst_addr", imem_addr, 0);
  endtask

  // IDLE -> FETCH, with noise on inputs that IDLE must ignore.
  task automatic do_start();
    quiet_inputs();
    start = 1; ack = 1'($urandom); done = 1'($urandom);
    #1;
    chk("idle_state", 32'(state), 0);
    chk("idle_strobes", {28'h0, imem_req, ir_valid, pc_en, pc_sel}, 0);
    chk("idle_ir", ir, exp_ir);
    cycle();
    quiet_inputs();
    exp_state = 1;
    chk("start_state", 32'(state), 1);
  endtask

  // One instruction through FETCH (d wait cycles then ack), EXEC (e cycles
  // then done) and UPDATE.
  task automatic run_instr(input logic [31:0] ipc, input logic [31:0] word,
                           input int d, input int e, input logic red, input logic hlt);
    if (exp_state == 0) do_start();
    for (int k = 0; k <= d; k++) begin
      quiet_inputs();
      pc    = ipc;
      ack   = (k == d);
      rdata = (k == d) ? word : 32'($urandom);
      done  = 1'($urandom);
      start = 1'($urandom);
      #1;
      chk("fetch_state", 32'(state), 1);
      chk("fetch_req_addr", {imem_req, imem_addr[30:0]}, {1'b1, ipc[30:0]});
      chk("fetch_addr_msb", 32'(imem_addr[31]), 32'(ipc[31]));
      chk("fetch_strobes", {29'h0, ir_valid, pc_en, pc_sel}, 0);
      cycle();
    end
    exp_ir = word;
    for (int k = 0; k <= e; k++) begin
      quiet_inputs();
      done     = (k == e);
      redirect = (k == e) ? red : 1'($urandom);
      halt     = (k == e) ? hlt : 1'($urandom);
      ack      = 1'($urandom);
      start    = 1'($urandom);
      #1;
      chk("exec_state", 32'(state), 2);
      chk("exec_ir", ir, exp_ir);
      chk("exec_valid", {28'h0, ir_valid, imem_req, pc_en, pc_sel}, 32'h8);
      chk("exec_addr", imem_addr, 0);
      cycle();
    end
    quiet_inputs();
    start = 1'($urandom); ack = 1'($urandom); done = 1'($urandom);
    #1;
    chk("upd_state", 32'(state), 3);
    chk("upd_pc_en", 32'(pc_en), 1);
    chk("upd_pc_sel", 32'(pc_sel), 32'(red));
    chk("upd_req_valid", {30'h0, imem_req, ir_valid}, 0);
    cycle();
    quiet_inputs();
    exp_instret = exp_instret + 32'd1;
    exp_state   = hlt ? 3'd0 : 3'd1;
    #1;
    chk("post_state", 32'(state), 32'(exp_state));
    chk("post_instret", instret, exp_instret);
    chk("post_pc_en_sel", {30'h0, pc_en, pc_sel}, 0);
    chk("post_fault", 32'(fault), 0);
  endtask

  initial begin
    rst = 0;
    quiet_inputs();
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // Basic instruction, immediate ack/done, sequential.
    run_instr(32'h0, 32'h0050_0093, 0, 0, 1'b0, 1'b0);
    chk("basic_ir", ir, 32'h0050_0093);
    chk("basic_instret", instret, 1);

    // Redirect; next fetch presents the new PC.
    run_instr(32'h4, 32'h0080_006f, 0, 1, 1'b1, 1'b0);
    run_instr(32'h0000_0100, 32'h0000_0013, 2, 0, 1'b0, 1'b0);

    // Ack on the last allowed FETCH cycle: no fault.
    run_instr(32'h0000_0104, 32'h1234_5678, TIMEOUT - 1, 0, 1'b0, 1'b0);
    chk("late_ack_fault", 32'(fault), 0);

    // Redirect and halt together: pc_sel=1, then IDLE.
    run_instr(32'h0000_0108, 32'h0000_0073, 0, 2, 1'b1, 1'b1);
    repeat (3) begin
      quiet_inputs();
      ack = 1; done = 1;
      cycle();
      chk("halt_idle", 32'(state), 0);
    end

    // Randomized instruction stream.
    for (int n = 0; n < 60; n++) begin
      run_instr($urandom, $urandom, $urandom_range(0, TIMEOUT - 1),
                $urandom_range(0, 3), 1'($urandom), ($urandom_range(0, 7) == 0));
    end

    // Instret wrap.
    if (exp_state != 0) run_instr($urandom, $urandom, 0, 0, 1'b0, 1'b1);
    force dut.r_instret = 32'hFFFF_FFFF;
    #1;
    release dut.r_instret;
    exp_instret = 32'hFFFF_FFFF;
    #1;
    chk("wrap_preset", instret, 32'hFFFF_FFFF);
    run_instr(32'h200, 32'hdead_beef, 1, 0, 1'b0, 1'b0);
    chk("wrap_zero", instret, 0);

    // Reset mid-EXEC.
    quiet_inputs();
    pc = 32'h204; ack = 1; rdata = 32'hcafe_f00d;
    cycle();
    quiet_inputs();
    chk("pre_rst_exec", 32'(state), 2);
    chk("pre_rst_ir", ir, 32'hcafe_f00d);
    do_reset();

    // Fetch timeout.
    do_start();
    for (int k = 0; k < TIMEOUT; k++) begin
      quiet_inputs();
      done = 1'($urandom);
      #1;
      chk("to_fetch_state", 32'(state), 1);
      chk("to_fetch_fault", 32'(fault), 0);
      cycle();
    end
    chk("to_fault_state", 32'(state), 4);
    chk("to_fault_flag", 32'(fault), 1);
    repeat (4) begin
      quiet_inputs();
      start = 1; ack = 1; done = 1;
      #1;
      chk("fault_strobes", {28'h0, imem_req, ir_valid, pc_en, pc_sel}, 0);
      cycle();
      chk("fault_sticky", {29'h0, state}, 4);
      chk("fault_flag_held", 32'(fault), 1);
    end

    // Reset mid-FETCH then normal operation resumes.
    do_reset();
    do_start();
    quiet_inputs();
    cycle();
    chk("mid_fetch_wait", 32'(state), 1);
    do_reset();
    run_instr(32'h0, 32'h0050_0093, 0, 0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
